uart_tx_arbiter: RTL

//  Shares one UART transmitter among N_REQ byte-stream requesters (debug console, log engine, DMA, ...).

---
 rtl/uart_tx_arbiter_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_rr.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Purpose : shared definitions for the UART TX arbiter block: arbiter FSM
//           state encoding, requester limit and a one-hot to index helper.
// Ports   : none (package)
// Config  : UART_ARB_CHID_EN selects whether ARB_HDR is reachable (top only).
// ----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HDR  = 2'd1,
        ARB_DATA = 2'd2
    } ArbState_t;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [2:0] onehot_idx(input logic [UART_ARB_MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < UART_ARB_MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_rr
// Purpose : combinational round-robin pick. Returns the first requester at or
//           after the pointer, wrapping N_REQ-1 -> 0.
// Ports   : i_req   [N_REQ]  request vector
//           i_ptr   [PTR_W]  round-robin start position
//           o_pick  [N_REQ]  one-hot winner (0 when no request)
//           o_any            any request present
// ----------------------------------------------------------------------------
module uart_tx_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_any
);

    always_comb begin : pick_blk
        int  j;
        logic w_found;
        j       = 0;
        w_found = 1'b0;
        o_pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(i_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!w_found && i_req[j]) begin
                o_pick[j] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Purpose : shares one UART TX data port among N_REQ byte-stream requesters.
//           Round-robin, packet-locked: a grant holds until the owner's last
//           beat or MAX_BURST beats (0 = unlimited), then re-arbitrates.
//           Output is a registered valid/ready stage.
// Ports   : clk, rst_n                 clock, async active-low reset
//           req_valid_i  [N_REQ]       requester beat valid
//           req_data_i   [N_REQ*DATA_W] beats, requester k at [k*DATA_W +: DATA_W]
//           req_last_i   [N_REQ]       last beat of packet
//           req_ready_o  [N_REQ]       beat accepted on valid&ready (one-hot/0)
//           tx_d_o       [DATA_W]      beat to UART TX
//           tx_d_valid_o               tx_d_o valid
//           tx_d_ready_i               UART TX accepts beat
//           grant_o      [N_REQ]       one-hot owner, 0 in IDLE
//           busy_o                     FSM not idle or output register full
// Config  : `define UART_ARB_CHID_EN to emit a header beat {1'b1, 8'(g)} at
//           the start of every grant (including resumed capped packets).
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 9,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       tx_d_o,
    output logic                    tx_d_valid_o,
    input  logic                    tx_d_ready_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int BC_W   = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int CAP_M1 = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

    ArbState_t          r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   r_ptr;
    logic [BC_W-1:0]    r_bcnt;
    logic [DATA_W-1:0]  r_tx_d;
    logic               r_tx_v;

    logic [N_REQ-1:0]   w_pick;
    logic               w_any;
    logic               w_out_free;
    logic               w_in_data;
    logic [DATA_W-1:0]  w_beat;
    logic               w_last;
    logic               w_accept;
    logic               w_cap;
    logic               w_release;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [PTR_W-1:0]   w_pick_idx;

    uart_tx_arbiter_rr #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req  (req_valid_i),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_pick_idx = PTR_W'(onehot_idx(UART_ARB_MAX_REQ'(w_pick)));

    // Output register can take a new beat when empty or draining this cycle.
    assign w_out_free = !r_tx_v || tx_d_ready_i;
    assign w_in_data  = (r_state == ARB_DATA);
    assign w_beat     = req_data_i[int'(r_gidx)*DATA_W +: DATA_W];
    assign w_last     = req_last_i[r_gidx];
    assign w_accept   = w_in_data && w_out_free && req_valid_i[r_gidx];

    // Cap fires on the beat that brings the count to MAX_BURST; last and cap
    // on the same beat collapse into one release.
    assign w_cap      = (MAX_BURST != 0) && (r_bcnt == BC_W'(CAP_M1));
    assign w_release  = w_accept && (w_last || w_cap);
    assign w_next_ptr = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

`ifdef UART_ARB_CHID_EN
    logic [DATA_W-1:0] w_hdr;
    assign w_hdr = DATA_W'({1'b1, 8'(r_gidx)});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            r_tx_d  <= '0;
            r_tx_v  <= 1'b0;
        end else begin
            // Drain; a load below in the same cycle overrides this.
            if (r_tx_v && tx_d_ready_i) r_tx_v <= 1'b0;

            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
`ifdef UART_ARB_CHID_EN
                        r_state <= ARB_HDR;
`else
                        r_state <= ARB_DATA;
`endif
                    end
                end
`ifdef UART_ARB_CHID_EN
                ARB_HDR: begin
                    // Header uses the output register but not the burst count.
                    if (w_out_free) begin
                        r_tx_d  <= w_hdr;
                        r_tx_v  <= 1'b1;
                        r_state <= ARB_DATA;
                    end
                end
`endif
                ARB_DATA: begin
                    if (w_accept) begin
                        r_tx_d <= w_beat;
                        r_tx_v <= 1'b1;
                        if (w_release) begin
                            r_state <= ARB_IDLE;
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                            r_bcnt  <= '0;
                        end else if (MAX_BURST != 0) begin
                            r_bcnt  <= r_bcnt + BC_W'(1);
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (w_in_data && w_out_free) ? r_grant : '0;
    assign tx_d_o       = r_tx_d;
    assign tx_d_valid_o = r_tx_v;
    assign grant_o      = r_grant;
    assign busy_o       = (r_state != ARB_IDLE) || r_tx_v;

endmodule
